// File: rtl/bitplane_serializer_16x4_if.sv
// Frame-in / bit-plane-out bus for bitplane_serializer_16x4.
// The slave modport is the serializer; the master modport is the frame source and plane sink.
interface bitplane_serializer_16x4_if #(
    parameter int unsigned M = 16,
    parameter int unsigned N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [M*N-1:0] in_data;
    logic [M-1:0]   data_bits;
    logic           bits_valid;
    logic           bits_first;
    logic           bits_last;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  data_bits,
        input  bits_valid,
        input  bits_first,
        input  bits_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output data_bits,
        output bits_valid,
        output bits_first,
        output bits_last
    );
endinterface

// File: rtl/bitplane_serializer_16x4.sv
// Serializes frames of M N-bit operands into N M-bit planes, LSB plane first.
// One frame may wait in a pending buffer so back-to-back frames stream with no gap.
module bitplane_serializer_16x4 #(
    parameter int unsigned M = 16,
    parameter int unsigned N = 4
) (
    input logic                       clk,
    input logic                       rst,
    bitplane_serializer_16x4_if.slave bus
);
    localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t         state_q;
    logic [M*N-1:0] sr_q;
    logic [M*N-1:0] pb_q;
    logic           pb_full_q;
    logic [CW-1:0]  cnt_q;
    logic [M-1:0]   data_bits_q;
    logic           bits_valid_q;
    logic           bits_first_q;
    logic           bits_last_q;
    logic           xfer;

    // Operand k's current LSB lands at plane bit M-1-k.
    function automatic logic [M-1:0] plane_of(input logic [M*N-1:0] f);
        logic [M-1:0] p;
        p = '0;
        for (int k = 0; k < M; k++) begin
            p[M-1-k] = f[N*k];
        end
        return p;
    endfunction

    // Shift every operand right by one so the next plane sits in each LSB.
    function automatic logic [M*N-1:0] shift_ops(input logic [M*N-1:0] f);
        logic [M*N-1:0] o;
        o = '0;
        for (int k = 0; k < M; k++) begin
            o[N*k +: N] = f[N*k +: N] >> 1;
        end
        return o;
    endfunction

    assign bus.in_ready   = !pb_full_q && !rst;
    assign xfer           = bus.in_valid && bus.in_ready;
    assign bus.data_bits  = data_bits_q;
    assign bus.bits_valid = bits_valid_q;
    assign bus.bits_first = bits_first_q;
    assign bus.bits_last  = bits_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sr_q         <= '0;
            pb_q         <= '0;
            pb_full_q    <= 1'b0;
            cnt_q        <= '0;
            data_bits_q  <= '0;
            bits_valid_q <= 1'b0;
            bits_first_q <= 1'b0;
            bits_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        state_q      <= StShift;
                        sr_q         <= bus.in_data;
                        cnt_q        <= '0;
                        data_bits_q  <= plane_of(bus.in_data);
                        bits_valid_q <= 1'b1;
                        bits_first_q <= 1'b1;
                        bits_last_q  <= (N == 1);
                    end
                end
                StShift: begin
                    if (cnt_q != LastCnt) begin
                        sr_q         <= shift_ops(sr_q);
                        cnt_q        <= cnt_q + CW'(1);
                        data_bits_q  <= plane_of(shift_ops(sr_q));
                        bits_first_q <= 1'b0;
                        bits_last_q  <= (cnt_q + CW'(1)) == LastCnt;
                        if (xfer) begin
                            pb_q      <= bus.in_data;
                            pb_full_q <= 1'b1;
                        end
                    end else if (pb_full_q) begin
                        // Waiting frame takes over on the last-plane edge: no bubble.
                        sr_q         <= pb_q;
                        pb_full_q    <= 1'b0;
                        cnt_q        <= '0;
                        data_bits_q  <= plane_of(pb_q);
                        bits_first_q <= 1'b1;
                        bits_last_q  <= (N == 1);
                    end else if (xfer) begin
                        sr_q         <= bus.in_data;
                        cnt_q        <= '0;
                        data_bits_q  <= plane_of(bus.in_data);
                        bits_first_q <= 1'b1;
                        bits_last_q  <= (N == 1);
                    end else begin
                        state_q      <= StIdle;
                        cnt_q        <= '0;
                        data_bits_q  <= '0;
                        bits_valid_q <= 1'b0;
                        bits_first_q <= 1'b0;
                        bits_last_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_bitplane_serializer_16x4.sv
// Randomized and directed bench for bitplane_serializer_16x4 against a plane-queue model.
// The model keeps every not-yet-consumed plane in a queue; its head is what must be on the outputs.
module tb_bitplane_serializer_16x4;
    localparam int unsigned M = 16;
    localparam int unsigned N = 4;
    localparam int unsigned W = M * N;

    typedef struct {
        logic [M-1:0] bits;
        logic         first;
        logic         last;
    } plane_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    plane_t q[$];

    bitplane_serializer_16x4_if #(.M(M), .N(N)) bus ();

    bitplane_serializer_16x4 #(.M(M), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Plane i of a frame: bit M-1-k holds bit i of operand k.
    task automatic push_frame(input logic [W-1:0] d);
        for (int i = 0; i < N; i++) begin
            plane_t p;
            for (int k = 0; k < M; k++) begin
                p.bits[M-1-k] = ((d >> (N * k)) >> i) & 1;
            end
            p.first = (i == 0);
            p.last  = (i == N - 1);
            q.push_back(p);
        end
    endtask

    task automatic check_out(input string tag);
        if (q.size() == 0) begin
            chk({tag, "_data"},  32'(bus.data_bits),  32'h0);
            chk({tag, "_valid"}, 32'(bus.bits_valid), 32'h0);
            chk({tag, "_first"}, 32'(bus.bits_first), 32'h0);
            chk({tag, "_last"},  32'(bus.bits_last),  32'h0);
        end else begin
            chk({tag, "_data"},  32'(bus.data_bits),  32'(q[0].bits));
            chk({tag, "_valid"}, 32'(bus.bits_valid), 32'h1);
            chk({tag, "_first"}, 32'(bus.bits_first), 32'(q[0].first));
            chk({tag, "_last"},  32'(bus.bits_last),  32'(q[0].last));
        end
    endtask

    // A frame is waiting exactly when more than N planes are outstanding.
    task automatic step(input logic v, input logic [W-1:0] d, output logic took);
        logic exp_rdy;
        bus.in_valid = v;
        bus.in_data  = d;
        #1;
        exp_rdy = !in_rst && (q.size() <= N);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        took = v && exp_rdy;
        if (q.size() > 0) q.delete(0);
        if (took) push_frame(d);
        #1;
        check_out("out");
    endtask

    function automatic logic [W-1:0] pack(input int unsigned ops[M]);
        logic [W-1:0] d;
        d = '0;
        for (int k = 0; k < M; k++) begin
            d[N*k +: N] = N'(ops[k]);
        end
        return d;
    endfunction

    initial begin
        int unsigned  ops[M];
        int unsigned  ref_ops[8];
        logic [W-1:0] frame;
        logic [W-1:0] bp[3];
        logic [M-1:0] want[4];
        logic         took;
        int           acc;
        int           tries;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset holds everything low, including in_ready.
        #2;
        check_out("rst");
        chk("rst_ready", 32'(bus.in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #3;
        check_out("rst_hold");
        rst = 1'b0;
        in_rst = 1'b0;
        #1;
        chk("rel_ready", 32'(bus.in_ready), 32'h1);

        // Reference frame: known planes and a weighted-sum self-check.
        ref_ops = '{2, 1, 2, 3, 4, 6, 7, 1};
        for (int k = 0; k < M; k++) ops[k] = ref_ops[k % 8];
        frame = pack(ops);
        want = '{16'h5353, 16'hB6B6, 16'h0E0E, 16'h0000};
        acc = 0;
        for (int i = 0; i < N; i++) begin
            step((i == 0), frame, took);
            chk("ref_plane", 32'(bus.data_bits), 32'(want[i]));
            chk("ref_first", 32'(bus.bits_first), 32'(i == 0));
            chk("ref_last", 32'(bus.bits_last), 32'(i == N - 1));
            acc += $countones(bus.data_bits) << i;
        end
        chk("ref_accum", 32'(acc), 32'd52);
        step(1'b0, '0, took);
        chk("ref_idle_valid", 32'(bus.bits_valid), 32'h0);
        step(1'b0, '0, took);

        // Back-to-back: all-ones frame then all-zeros frame.
        step(1'b1, {W{1'b1}}, took);
        chk("b2b_a_took", 32'(took), 32'h1);
        step(1'b1, '0, took);
        chk("b2b_b_took", 32'(took), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, took);
        end

        // Backpressure: in_valid held high across three frames.
        for (int f = 0; f < 3; f++) bp[f] = {$urandom, $urandom};
        for (int f = 0; f < 3; f++) begin
            tries = 0;
            do begin
                step(1'b1, bp[f], took);
                tries++;
            end while (!took && tries < 16);
            chk("bp_accept", 32'(took), 32'h1);
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, took);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, took);
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, took);

        // Reset mid-frame with the pending buffer full.
        step(1'b1, {$urandom, $urandom}, took);
        step(1'b1, {$urandom, $urandom}, took);
        chk("mid_pb_full", 32'(bus.in_ready), 32'h0);
        #2;
        rst = 1'b1;
        in_rst = 1'b1;
        q.delete();
        bus.in_valid = 1'b1;
        #1;
        check_out("mid_rst");
        chk("mid_rst_ready", 32'(bus.in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_out("mid_rst_hold");
        #2;
        rst = 1'b0;
        in_rst = 1'b0;
        bus.in_valid = 1'b0;
        step(1'b1, {$urandom, $urandom}, took);
        chk("post_rst_took", 32'(took), 32'h1);
        chk("post_rst_first", 32'(bus.bits_first), 32'h1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, took);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
